uart_char_source: RTL and testbench

//  Serial front end of the serial terminal. Receives 8N1 UART bytes on i_rx and buffers them
//  in a FIFO that absorbs bursts arriving while the text controller is busy scrolling or

---
 rtl/uart_char_source_if.sv | 35 +++
 rtl/uart_char_source.sv | 189 ++++++++++++++++++
 tb/tb_uart_char_source.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_char_source_if.sv
// Character-source bus between the UART front end and the text controller.
// Carries the raw serial line in, and the valid/ready byte stream plus status out.
interface uart_char_source_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     rx;
  logic [7:0]               data;
  logic                     valid;
  logic                     ready;
  logic                     overrun;
  logic                     frame_err;
  logic [FIFO_DEPTH_LOG2:0] level;

  // Producer side: the UART receiver with its byte FIFO.
  modport master (
    input  rx,
    input  ready,
    output data,
    output valid,
    output overrun,
    output frame_err,
    output level
  );

  // Environment side: drives the serial line and consumes characters.
  modport slave (
    output rx,
    output ready,
    input  data,
    input  valid,
    input  overrun,
    input  frame_err,
    input  level
  );
endinterface

// File: rtl/uart_char_source.sv
// uart_char_source: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Bytes that arrive while the FIFO is full (and nothing is popped that cycle) are
// dropped with a one-cycle overrun pulse.
// Optional build macro UART_FRAME_CHECK_EN: bytes with a low stop bit are discarded,
// frame_err pulses, and the receiver waits for the line to go idle before re-arming.
// Without the macro the byte is pushed regardless of the stop bit and frame_err is 0.
module uart_char_source #(
  parameter int CLK_HZ          = 12_000_000,
  parameter int BAUD            = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_char_source_if.master  bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam int LVL_W        = FIFO_DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  // BRK is only entered when frame checking is built in.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic                       rx_meta;
  logic                       rxs;
  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [2:0]                 bit_idx;
  logic [7:0]                 shift;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_next;
  logic [LVL_W-1:0]           level;
  logic [7:0]                 head;
  logic                       overrun;

  logic                       stop_tick;
  logic                       push_req;
  logic                       pop;
  logic                       full;
  logic                       push;

  // The stop bit is sampled on the cycle the counter expires in STOP.
  assign stop_tick = (state == STOP) && (cnt == '0);
`ifdef UART_FRAME_CHECK_EN
  logic frame_err;
  assign push_req  = stop_tick & rxs;
`else
  assign push_req  = stop_tick;
`endif
  assign pop     = (level != '0) & bus.ready;
  assign full    = (level == LVL_W'(DEPTH));
  assign push    = push_req & (~full | pop);
  assign rd_next = rd_ptr + 1'b1;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM: start-bit qualification at mid-bit, then 8 data bits LSB first and the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
`ifdef UART_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
`ifdef UART_FRAME_CHECK_EN
      frame_err <= stop_tick & ~rxs;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= FULL_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift <= {rxs, shift[7:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
`ifdef UART_FRAME_CHECK_EN
            // A low stop bit means a break: hold off until the line returns high.
            state <= rxs ? IDLE : BRK;
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BRK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers, occupancy, registered head byte and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req & full & ~pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // The incoming byte becomes the head directly when nothing else is queued ahead of it.
      if (push && ((level == '0) || (pop && (level == LVL_W'(1))))) begin
        head <= shift;
      end else if (pop) begin
        head <= mem[rd_next];
      end
    end
  end

  assign bus.data    = head;
  assign bus.valid   = (level != '0);
  assign bus.level   = level;
  assign bus.overrun = overrun;
`ifdef UART_FRAME_CHECK_EN
  assign bus.frame_err = frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_char_source.sv
// Self-checking bench for uart_char_source: directed steps with random payloads,
// checked against a queue model of the FIFO contents and pulse counters.
module tb_uart_char_source;

  localparam int CPB       = 12_000_000 / 115200;      // clocks per bit
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;    // edges from start-bit drive to stop sample
  localparam int DEPTH     = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_char_source_if #(.FIFO_DEPTH_LOG2(4)) bus ();

  uart_char_source #(
    .CLK_HZ(12_000_000),
    .BAUD(115200),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int ovr_cycles = 0;
  int ferr_cycles = 0;
  int exp_ovr = 0;
  int exp_ferr = 0;
  logic [7:0] exp_q[$];

  // Count the cycles each status pulse is high.
  always @(negedge clk) begin
    if (!rst && bus.overrun === 1'b1) ovr_cycles++;
    if (!rst && bus.frame_err === 1'b1) ferr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a received byte joins the queue unless it is already full.
  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr++;
  endtask

  // Drive one 8N1 frame starting at a falling clock edge; optional one-cycle ready pulse
  // on the cycle of the stop sample, optional first-byte latency check.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int ready_at,
                           input bit chk_lat);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      bus.rx = frame[i / CPB];
      if (ready_at >= 0) begin
        bus.ready = (i == ready_at);
        if (i == ready_at) check("level_at_pop", 32'(bus.level), 32'(exp_q.size()));
      end
      if (chk_lat && i == STOP_EDGE - 1) check("lat_before", 32'(bus.valid), 32'd0);
      if (chk_lat && i == STOP_EDGE) begin
        check("lat_valid", 32'(bus.valid), 32'd1);
        check("lat_char", 32'(bus.data), 32'(b));
      end
      @(negedge clk);
    end
    bus.rx = 1'b1;
    bus.ready = 1'b0;
    $display("tx byte 0x%02h stop=%0d level=%0d", b, stop_bit, bus.level);
  endtask

  // Pop everything the model holds, checking head, valid and level each cycle.
  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      check("drain_level", 32'(bus.level), 32'(exp_q.size()));
      check("drain_valid", 32'(bus.valid), 32'd1);
      check("drain_char", 32'(bus.data), 32'(exp_q[0]));
      bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.ready) begin
        $display("rx byte 0x%02h", exp_q[0]);
        void'(exp_q.pop_front());
      end
      n++;
    end
    bus.ready = 1'b0;
    check("drain_in_budget", 32'(n < 400), 32'd1);
    check("drain_empty_valid", 32'(bus.valid), 32'd0);
    check("drain_empty_level", 32'(bus.level), 32'd0);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] frame;

    // Reset state
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_char", 32'(bus.data), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;

    // Idle line produces nothing
    idle(2000);
    check("idle_valid", 32'(bus.valid), 32'd0);
    check("idle_level", 32'(bus.level), 32'd0);
    check("idle_pulses", 32'(ovr_cycles + ferr_cycles), 32'd0);

    // Single byte, then a one-cycle pop
    send_byte(8'h41, 1'b1, -1, 1'b1);
    model_push(8'h41);
    check("single_valid", 32'(bus.valid), 32'd1);
    check("single_char", 32'(bus.data), 32'h41);
    check("single_level", 32'(bus.level), 32'd1);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    void'(exp_q.pop_front());
    check("single_popped", 32'(bus.valid), 32'd0);
    @(negedge clk);
    check("single_stays_empty", 32'(bus.level), 32'd0);

    // Burst of 17 into a 16-deep FIFO: last byte overruns
    for (int k = 0; k < 17; k++) begin
      send_byte(8'(8'h30 + k), 1'b1, -1, 1'b0);
      model_push(8'(8'h30 + k));
    end
    idle(5);
    check("burst_level", 32'(bus.level), 32'(DEPTH));
    check("burst_overrun", 32'(ovr_cycles), 32'(exp_ovr));
    drain(1'b0);

    // Full FIFO with a pop on the stop-sample cycle: byte accepted, no overrun
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1, -1, 1'b0);
      model_push(b);
    end
    b = 8'($urandom);
    send_byte(b, 1'b1, STOP_EDGE - 1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(b);
    idle(3);
    check("fullpop_level", 32'(bus.level), 32'(DEPTH));
    check("fullpop_overrun", 32'(ovr_cycles), 32'(exp_ovr));
    drain(1'b1);

    // Random bytes with random consumer stalls
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1, -1, 1'b0);
      model_push(b);
    end
    drain(1'b1);

    // Short glitch on the line is not a start bit
    bus.rx = 1'b0;
    repeat ($urandom_range(10, 40)) @(negedge clk);
    idle(200);
    check("glitch_valid", 32'(bus.valid), 32'd0);
    check("glitch_level", 32'(bus.level), 32'd0);
    send_byte(8'h0A, 1'b1, -1, 1'b1);
    model_push(8'h0A);
    check("after_glitch_char", 32'(bus.data), 32'h0A);
    drain(1'b0);

    // Stop bit sampled low
    send_byte(8'h55, 1'b0, -1, 1'b0);
`ifdef UART_FRAME_CHECK_EN
    exp_ferr++;
`else
    model_push(8'h55);
`endif
    idle(300);
    check("frame_err_pulses", 32'(ferr_cycles), 32'(exp_ferr));
    check("frame_level", 32'(bus.level), 32'(exp_q.size()));
    if (exp_q.size() != 0) check("frame_char", 32'(bus.data), 32'(exp_q[0]));

    // Asynchronous reset in the middle of a frame with data queued
    b = 8'($urandom);
    send_byte(b, 1'b1, -1, 1'b0);
    model_push(b);
    frame = {1'b1, 8'($urandom), 1'b0};
    for (int i = 0; i < 5 * CPB + 17; i++) begin
      bus.rx = frame[i / CPB];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.valid), 32'd0);
    check("midrst_char", 32'(bus.data), 32'd0);
    check("midrst_level", 32'(bus.level), 32'd0);
    check("midrst_overrun", 32'(bus.overrun), 32'd0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    bus.rx = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1200);
    check("postrst_level", 32'(bus.level), 32'd0);
    send_byte(8'h42, 1'b1, -1, 1'b1);
    model_push(8'h42);
    check("postrst_char", 32'(bus.data), 32'h42);
    check("postrst_level1", 32'(bus.level), 32'd1);
    drain(1'b0);
    check("final_overrun", 32'(ovr_cycles), 32'(exp_ovr));
    check("final_frame_err", 32'(ferr_cycles), 32'(exp_ferr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
